// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX and WB
//
// Optional feature macro: MEM_FWD_EN (drives the mem_fwd bypass to ID;
// without it mem_fwd is tied to zero).
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   ex_mem_valid          EX has an instruction for MEM
//   mem_allowin           MEM accepts an instruction this cycle
//   ex_pc .. ex_pass      EX payload latched on accept
//   ex_req_issued         EX issued an accepted data-SRAM request
//   data_sram_data_ok     data-SRAM response strobe
//   data_sram_rdata       data-SRAM response data
//   wb_allowin            WB accepts this cycle
//   wb_flush              WB kills the resident instruction this cycle
//   mem_wb_valid          instruction valid to WB
//   mem_wb_bus            {gr_we, pc, final_result, dest, pass}
//   mem_fwd               {fwd_valid, data_pending, dest, data} to ID
module mem_stage #(
  parameter int PASS_W = 200
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_mem_valid,
  output logic              mem_allowin,
  input  logic [31:0]       ex_pc,
  input  logic              ex_gr_we,
  input  logic [4:0]        ex_dest,
  input  logic [31:0]       ex_alu_result,
  input  logic [2:0]        ex_ld_op,
  input  logic              ex_req_issued,
  input  logic [PASS_W-1:0] ex_pass,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allowin,
  input  logic              wb_flush,
  output logic              mem_wb_valid,
  output logic [70+PASS_W-1:0] mem_wb_bus,
  output logic [38:0]       mem_fwd
);

  localparam logic [2:0] LD_W    = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_BU   = 3'd3;
  localparam logic [2:0] LD_HU   = 3'd4;
  localparam logic [2:0] LD_NONE = 3'd7;

  // Control state (reset)
  logic              mem_valid_q, mem_valid_d;
  logic              buf_valid_q, buf_valid_d;
  logic [1:0]        discard_cnt_q, discard_cnt_d;

  // Payload (not reset)
  logic [31:0]       pc_q, pc_d;
  logic              gr_we_q, gr_we_d;
  logic [4:0]        dest_q, dest_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic              need_resp_q, need_resp_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [31:0]       buf_q, buf_d;

  logic              resp_now;
  logic              ready_go;
  logic              accept;
  logic              disc_inc;
  logic              disc_dec;
  logic [31:0]       ld_src;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;
  logic [31:0]       final_result;

  // A response only counts for the resident instruction once every
  // response still owed to killed instructions has drained.
  assign resp_now    = data_sram_data_ok && (discard_cnt_q == 2'd0);
  assign ready_go    = !need_resp_q || buf_valid_q || resp_now;
  assign mem_allowin = !mem_valid_q || (ready_go && wb_allowin);
  assign accept      = mem_allowin && ex_mem_valid && !wb_flush;

  // Load alignment and extension
  always_comb begin
    ld_src  = buf_valid_q ? buf_q : data_sram_rdata;
    off     = alu_result_q[1:0];
    ld_byte = ld_src[{off, 3'b000} +: 8];
    ld_half = ld_src[{off[1], 4'b0000} +: 16];
    case (ld_op_q)
      LD_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_data = {24'd0, ld_byte};
      LD_H:    load_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_data = {16'd0, ld_half};
      LD_W:    load_data = ld_src;
      default: load_data = ld_src;
    endcase
    final_result = (ld_op_q != LD_NONE) ? load_data : alu_result_q;
  end

  // The killed instruction still owes a response when it was waiting and
  // nothing it could claim arrived this cycle. A data_ok that drains an
  // older discard does not satisfy it, so it is gated by resp_now.
  assign disc_inc = wb_flush && mem_valid_q && need_resp_q && !buf_valid_q && !resp_now;
  assign disc_dec = data_sram_data_ok && (discard_cnt_q != 2'd0);

  always_comb begin
    mem_valid_d   = mem_valid_q;
    buf_valid_d   = buf_valid_q;
    discard_cnt_d = discard_cnt_q;
    buf_d         = buf_q;

    case ({disc_inc, disc_dec})
      2'b10:   discard_cnt_d = (discard_cnt_q == 2'd3) ? 2'd3 : discard_cnt_q + 2'd1;
      2'b01:   discard_cnt_d = discard_cnt_q - 2'd1;
      default: discard_cnt_d = discard_cnt_q;
    endcase

    if (wb_flush) begin
      mem_valid_d = 1'b0;
      buf_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_mem_valid;
      buf_valid_d = 1'b0;
    end else if (resp_now && mem_valid_q && need_resp_q && !buf_valid_q && !wb_allowin) begin
      // Hold the response until WB can take the instruction.
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    gr_we_d      = gr_we_q;
    dest_d       = dest_q;
    alu_result_d = alu_result_q;
    ld_op_d      = ld_op_q;
    need_resp_d  = need_resp_q;
    pass_d       = pass_q;
    if (accept) begin
      pc_d         = ex_pc;
      gr_we_d      = ex_gr_we;
      dest_d       = ex_dest;
      alu_result_d = ex_alu_result;
      ld_op_d      = ex_ld_op;
      need_resp_d  = ex_req_issued;
      pass_d       = ex_pass;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q   <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= 2'd0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q         <= pc_d;
    gr_we_q      <= gr_we_d;
    dest_q       <= dest_d;
    alu_result_q <= alu_result_d;
    ld_op_q      <= ld_op_d;
    need_resp_q  <= need_resp_d;
    pass_q       <= pass_d;
    buf_q        <= buf_d;
  end

  assign mem_wb_valid = mem_valid_q && ready_go && !wb_flush;
  assign mem_wb_bus   = {gr_we_q, pc_q, final_result, dest_q, pass_q};

`ifdef MEM_FWD_EN
  logic fwd_valid;
  logic data_pending;
  assign fwd_valid    = mem_valid_q && gr_we_q && (dest_q != 5'd0);
  assign data_pending = (ld_op_q != LD_NONE) && !(buf_valid_q || resp_now);
  assign mem_fwd      = {fwd_valid, data_pending, dest_q, final_result};
`else
  assign mem_fwd = 39'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  localparam int PASS_W = 200;
  localparam int BUS_W  = 70 + PASS_W;

  logic              clk;
  logic              resetn;
  logic              ex_mem_valid;
  logic              mem_allowin;
  logic [31:0]       ex_pc;
  logic              ex_gr_we;
  logic [4:0]        ex_dest;
  logic [31:0]       ex_alu_result;
  logic [2:0]        ex_ld_op;
  logic              ex_req_issued;
  logic [PASS_W-1:0] ex_pass;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              wb_flush;
  logic              mem_wb_valid;
  logic [BUS_W-1:0]  mem_wb_bus;
  logic [38:0]       mem_fwd;

  mem_stage #(.PASS_W(PASS_W)) dut (
    .clk(clk), .resetn(resetn),
    .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
    .ex_alu_result(ex_alu_result), .ex_ld_op(ex_ld_op),
    .ex_req_issued(ex_req_issued), .ex_pass(ex_pass),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_flush(wb_flush),
    .mem_wb_valid(mem_wb_valid), .mem_wb_bus(mem_wb_bus), .mem_fwd(mem_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the resident instruction and the number of responses
  // still owed to instructions that were killed.
  bit              m_valid;
  bit              m_need;
  bit              m_got;
  logic [31:0]     m_data;
  int              m_stale;
  logic [31:0]     m_pc;
  bit              m_gr_we;
  logic [4:0]      m_dest;
  logic [31:0]     m_alu;
  logic [2:0]      m_ld;
  logic [PASS_W-1:0] m_pass;

  function automatic logic [31:0] extract(input logic [2:0] op, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hff;
    h = (w >> (16 * (off / 2))) & 32'hffff;
    case (op)
      3'd1:    return (b >= 32'd128) ? (b | 32'hffffff00) : b;
      3'd3:    return b;
      3'd2:    return (h >= 32'd32768) ? (h | 32'hffff0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic int outstanding();
    return m_stale + ((m_valid && m_need && !m_got) ? 1 : 0);
  endfunction

  // Called at a negedge: compare against the model, then advance it over
  // the following posedge and return 1 ns after that edge.
  task automatic tick();
    bit to_res, have, ex_allow, exp_v;
    logic [31:0] src, res;
    logic [BUS_W-1:0] exp_bus;
    bit i_rst, i_exv, i_dok, i_wba, i_fl;
    i_rst = resetn; i_exv = ex_mem_valid; i_dok = data_sram_data_ok;
    i_wba = wb_allowin; i_fl = wb_flush;

    to_res   = i_dok && (m_stale == 0);
    have     = m_valid && (!m_need || m_got || to_res);
    ex_allow = !m_valid || (have && i_wba);
    exp_v    = have && !i_fl;
    src      = m_got ? m_data : data_sram_rdata;
    res      = (m_ld != 3'd7) ? extract(m_ld, int'(m_alu[1:0]), src) : m_alu;
    exp_bus  = {m_gr_we, m_pc, res, m_dest, m_pass};

    check("allowin", mem_allowin, ex_allow);
    check("wb_valid", mem_wb_valid, exp_v);
    if (exp_v) check("wb_bus", mem_wb_bus, exp_bus);
`ifdef MEM_FWD_EN
    check("fwd_valid", mem_fwd[38], m_valid && m_gr_we && (m_dest != 0));
    if (m_valid && m_gr_we && (m_dest != 0))
      check("fwd_body", mem_fwd[37:0],
            {(m_ld != 3'd7) && !(m_got || to_res), m_dest, res});
`else
    check("fwd_zero", mem_fwd, 39'd0);
`endif

    @(posedge clk);
    if (!i_rst) begin
      m_valid = 0;
      m_stale = 0;
    end else begin
      if (i_dok && m_stale > 0) m_stale--;
      if (i_fl) begin
        if (m_valid && m_need && !m_got && !to_res) m_stale = (m_stale >= 3) ? 3 : m_stale + 1;
        m_valid = 0;
      end else if (ex_allow) begin
        m_valid = i_exv;
        if (i_exv) begin
          m_pc = ex_pc; m_gr_we = ex_gr_we; m_dest = ex_dest; m_alu = ex_alu_result;
          m_ld = ex_ld_op; m_need = ex_req_issued; m_pass = ex_pass; m_got = 0;
        end
      end else if (to_res) begin
        m_got  = 1;
        m_data = data_sram_rdata;
      end
    end
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    tick();
  endtask

  task automatic set_ex(input bit v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [2:0] ld, input bit req);
    ex_mem_valid  = v;
    ex_pc         = pc;
    ex_gr_we      = 1'b1;
    ex_dest       = 5'd4;
    ex_alu_result = alu;
    ex_ld_op      = ld;
    ex_req_issued = req;
    for (int i = 0; i < PASS_W; i += 32) ex_pass[i +: 8] = 8'($urandom);
  endtask

  function automatic logic [31:0] bus_res();
    return mem_wb_bus[PASS_W + 5 +: 32];
  endfunction

  // Small directed load: accept, wait 'lat' cycles, then data_ok with 'rd'.
  task automatic load_case(input string tag, input logic [31:0] alu, input logic [2:0] ld,
                           input int lat, input logic [31:0] rd, input logic [31:0] exp);
    set_ex(1, 32'h1c000100, alu, ld, 1);
    cyc();
    ex_mem_valid = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, "_stall"}, mem_allowin, 1'b0);
      tick();
    end
    data_sram_data_ok = 1; data_sram_rdata = rd;
    @(negedge clk);
    check({tag, "_valid"}, mem_wb_valid, 1'b1);
    check({tag, "_res"}, bus_res(), exp);
    tick();
    data_sram_data_ok = 0;
  endtask

  initial begin
    resetn = 0; ex_mem_valid = 0; ex_pc = 0; ex_gr_we = 0; ex_dest = 0;
    ex_alu_result = 0; ex_ld_op = 3'd7; ex_req_issued = 0; ex_pass = '0;
    data_sram_data_ok = 0; data_sram_rdata = 0; wb_allowin = 1; wb_flush = 0;
    m_valid = 0; m_stale = 0; m_need = 0; m_got = 0; m_data = 0;
    m_pc = 0; m_gr_we = 0; m_dest = 0; m_alu = 0; m_ld = 3'd7; m_pass = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;

    @(negedge clk);
    check("rst_wb_valid", mem_wb_valid, 1'b0);
    check("rst_allowin", mem_allowin, 1'b1);
    check("rst_fwd", mem_fwd, 39'd0);
    tick();

    // ALU op reaches WB one cycle after accept
    set_ex(1, 32'h1c000000, 32'h12345678, 3'd7, 0);
    cyc();
    ex_mem_valid = 0;
    @(negedge clk);
    check("alu_valid", mem_wb_valid, 1'b1);
    check("alu_res", bus_res(), 32'h12345678);
    check("alu_pc", mem_wb_bus[PASS_W + 37 +: 32], 32'h1c000000);
    tick();

    load_case("ldb", 32'h00001003, 3'd1, 2, 32'h80AA5511, 32'hFFFFFF80);
    load_case("ldhu", 32'h00001002, 3'd4, 2, 32'h80AA5511, 32'h000080AA);

    // Response buffered while WB stalls for three cycles
    set_ex(1, 32'h1c000200, 32'h00002000, 3'd0, 1);
    cyc();
    ex_mem_valid = 0; wb_allowin = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE1234;
    cyc();
    data_sram_data_ok = 0;
    cyc(); cyc();
    wb_allowin = 1;
    @(negedge clk);
    check("buf_valid", mem_wb_valid, 1'b1);
    check("buf_res", bus_res(), 32'hCAFE1234);
    check("buf_allowin", mem_allowin, 1'b1);
    tick();

    // Flush while waiting, then the stale response is dropped
    set_ex(1, 32'h1c000300, 32'h00003000, 3'd0, 1);
    cyc();
    ex_mem_valid = 0;
    cyc();
    wb_flush = 1;
    cyc();
    wb_flush = 0;
    @(negedge clk);
    check("fl_mem_valid", dut.mem_valid_q, 1'b0);
    check("fl_discard", dut.discard_cnt_q, 2'd1);
    set_ex(1, 32'h1c000304, 32'h00003004, 3'd0, 1);
    tick();
    ex_mem_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD0000;
    @(negedge clk);
    check("stale_drop", mem_wb_valid, 1'b0);
    tick();
    data_sram_rdata = 32'h00000042;
    @(negedge clk);
    check("fresh_valid", mem_wb_valid, 1'b1);
    check("fresh_res", bus_res(), 32'h00000042);
    tick();
    data_sram_data_ok = 0;

    // Flush coincident with data_ok: response consumed by the killed load
    set_ex(1, 32'h1c000400, 32'h00004000, 3'd0, 1);
    cyc();
    ex_mem_valid = 0;
    wb_flush = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h11112222;
    @(negedge clk);
    check("flok_valid", mem_wb_valid, 1'b0);
    tick();
    wb_flush = 0; data_sram_data_ok = 0;
    @(negedge clk);
    check("flok_discard", dut.discard_cnt_q, 2'd0);
    tick();

    // Reset during a wait with a discard pending
    set_ex(1, 32'h1c000500, 32'h00005000, 3'd0, 1);
    cyc();
    ex_mem_valid = 0;
    wb_flush = 1;
    cyc();
    wb_flush = 0;
    set_ex(1, 32'h1c000504, 32'h00005004, 3'd0, 1);
    cyc();
    ex_mem_valid = 0;
    resetn = 0;
    cyc();
    resetn = 1;
    @(negedge clk);
    check("mrst_mem_valid", dut.mem_valid_q, 1'b0);
    check("mrst_discard", dut.discard_cnt_q, 2'd0);
    check("mrst_allowin", mem_allowin, 1'b1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] ops [6];
      ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
      ex_mem_valid  = ($urandom_range(0, 9) < 7);
      ex_pc         = $urandom;
      ex_gr_we      = 1'($urandom);
      ex_dest       = 5'($urandom);
      ex_alu_result = $urandom;
      ex_ld_op      = ops[$urandom_range(0, 5)];
      ex_req_issued = (ex_ld_op != 3'd7) ? 1'b1 : ($urandom_range(0, 9) < 3);
      for (int i = 0; i < PASS_W; i += 32) ex_pass[i +: 8] = 8'($urandom);
      wb_allowin        = ($urandom_range(0, 3) != 0);
      wb_flush          = (m_stale < 2) && ($urandom_range(0, 19) == 0);
      data_sram_data_ok = (outstanding() > 0) && ($urandom_range(0, 9) < 4);
      data_sram_rdata   = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB.
- Latches EX results and waits for the data-SRAM response of a load/store issued in EX.
- Aligns and extends load data, then presents one instruction per handshake to WB.
- On WB flush (exception/ertn/TLB refetch), kills the resident instruction and discards any data-SRAM response still owed to it.

Parameters:
- PASS_W, 200, width of opaque sideband (CSR/exception/TLB fields) carried unchanged to WB.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ex_mem_valid  in  1  EX has an instruction for MEM
- mem_allowin  out  1  MEM accepts this cycle
- ex_pc  in  32  instruction PC
- ex_gr_we  in  1  writes GPR
- ex_dest  in  5  GPR destination
- ex_alu_result  in  32  ALU result / memory address
- ex_ld_op  in  3  0 LD_W, 1 LD_B, 2 LD_H, 3 LD_BU, 4 LD_HU, 7 not-load
- ex_req_issued  in  1  EX issued a data-SRAM request (load or store) that was accepted
- ex_pass  in  PASS_W  opaque sideband
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data
- wb_allowin  in  1  WB accepts
- wb_flush  in  1  WB exception/ertn/tlb refetch this cycle
- mem_wb_valid  out  1  valid to WB
- mem_wb_bus  out  70+PASS_W  {gr_we, pc, final_result, dest, pass}
- mem_fwd  out  39  {fwd_valid, data_pending, dest, data} bypass to ID

Behaviour:
- Reset: mem_valid=0, buf_valid=0, discard_cnt=0, payload registers unchanged. Outputs reset to mem_wb_valid=0, mem_allowin=1, mem_fwd=0.
- need_resp = latched ex_req_issued.
- resp_now = data_sram_data_ok && discard_cnt==0.
- ready_go = !need_resp || buf_valid || resp_now.
- mem_allowin = !mem_valid || (ready_go && wb_allowin).
- Combinational outputs:
  - mem_wb_valid = mem_valid && ready_go && !wb_flush.
  - mem_wb_bus.pc, gr_we, dest and pass are the latched EX fields.
  - mem_wb_bus.final_result = load data if ld_op≠7, else the latched alu_result.
- Accept: on mem_allowin && ex_mem_valid, latch all ex_* fields, set mem_valid=1 and clear buf_valid. If mem_allowin but !ex_mem_valid, mem_valid=0.
- Flush priority: wb_flush has priority over accept.
  - mem_valid<=0 and buf_valid<=0 next cycle.
  - If mem_valid && need_resp && !buf_valid && !data_sram_data_ok, discard_cnt increments (saturates at 3).
- Response buffer: resp_now while mem_valid && need_resp && !buf_valid && !wb_allowin captures rdata into buf, sets buf_valid=1.
- Discard: data_sram_data_ok with discard_cnt>0 decrements the count. The response is ignored and never satisfies ready_go. A flush and a data_ok in the same cycle: the data_ok belongs to the resident instruction, so the count is unchanged.
- Load data: src = buf_valid ? buf : data_sram_rdata. Select using off = alu_result[1:0].
  - LD_B / LD_BU: byte src[8*off+:8], sign-/zero-extended.
  - LD_H / LD_HU: halfword src[16*off[1]+:16], sign-/zero-extended.
  - LD_W: src unchanged.
- Stores: need_resp=1, final_result=alu_result, gr_we as given.
- Latency: non-memory instruction reaches WB the cycle after accept. Load: same cycle as data_ok, or from buffer once wb_allowin.
- No more than one outstanding response belongs to the resident instruction. Responses return in order.

Optional Feature:
- MEM_FWD_EN defined:
  - mem_fwd.fwd_valid = mem_valid && gr_we && dest≠0.
  - mem_fwd.data_pending = ld_op≠7 && !(buf_valid || resp_now).
  - mem_fwd.data = final_result.
- MEM_FWD_EN undefined: mem_fwd tied to 0 and ID stalls on MEM RAW hazards.

Test Plan:
- ALU op pc=0x1c000000, result 0x12345678, wb_allowin=1: mem_wb_valid one cycle after accept, final_result=0x12345678.
- LD_B with addr[1:0]=3, rdata=0x80AA5511, data_ok 2 cycles late: mem_allowin=0 while waiting, then final_result=0xFFFFFF80. Same with LD_HU addr[1:0]=2 → 0x000080AA.
- data_ok with wb_allowin=0 for 3 cycles: buffered. On wb_allowin=1, the same data goes out, no second response is needed, and mem_allowin rises that cycle.
- wb_flush while load waits with no data_ok: mem_valid=0, discard_cnt=1. Then a new load is accepted. The first data_ok (0xDEAD0000) is dropped, the second (0x00000042) gives the LD_W result 0x42.
- wb_flush in the same cycle as data_ok: discard_cnt stays 0 and mem_wb_valid=0 that cycle.
- Reset asserted mid-wait: next cycle mem_valid=0, discard_cnt=0, mem_allowin=1.
